sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one sram-like memory master port between the CPU's instruction-fetch requester and data-access requester.
- Sits between the mips core's inst/data sram-like interfaces and the single bridge toward the memory system, e.g. a later AXI bridge.
- Allows one outstanding transaction.
- Fixed data-first priority, with a bounded anti-starvation rule for instruction fetch.
- Routes each response back to the requester that owns it.

Parameters:
- MAX_DATA_STREAK, default 4: number of consecutive data grants allowed while an inst request is pending; the next grant is then forced to inst. Legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- inst_req  in  1  inst request; held until inst_addr_ok.
- inst_wr  in  1  write flag; 0 for fetch.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_addr  in  32  physical address.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  inst request accepted.
- inst_data_ok  out  1  inst response valid.
- inst_rdata  out  32  inst read data.
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same directions, widths and meanings for the data requester.
- mem_req  out  1  master request.
- mem_wr  out  1  master write flag.
- mem_size  out  2  master size.
- mem_addr  out  32  master address.
- mem_wdata  out  32  master write data.
- mem_addr_ok  in  1  slave accepted the request.
- mem_data_ok  in  1  slave response valid.
- mem_rdata  in  32  slave read data.

Behaviour:
- FSM states IDLE, ADDR, RESP; register owner (0=inst, 1=data); 4-bit streak counter; registered request latch for wr/size/addr/wdata.
- Reset (rst=1 at a clk edge):
  - state=IDLE, owner=0, streak=0, latch cleared.
  - All outputs 0, including mem_* and *_addr_ok/*_data_ok; rdata outputs 0.
- IDLE grant decision:
  - data_req=1 and (inst_req=0 or streak<MAX_DATA_STREAK): owner=data; streak increments (saturating) if inst_req=1, else clears to 0.
  - Otherwise inst_req=1: owner=inst, streak=0.
  - On any grant: latch the winner's fields, next state ADDR.
  - No request: stay IDLE; streak unchanged.
- ADDR:
  - mem_req=1; mem_wr/mem_size/mem_addr/mem_wdata driven from the latch, never directly from requester inputs.
  - mem_addr_ok=1: the owner's *_addr_ok=1 combinationally that cycle; next state RESP.
  - mem_addr_ok=0: hold ADDR indefinitely with stable outputs.
- RESP:
  - mem_req=0.
  - mem_data_ok=1: the owner's *_data_ok=1 combinationally and its *_rdata=mem_rdata; next state IDLE.
  - The non-owner's *_data_ok is always 0; its rdata is held at 0.
- Latency:
  - Request first seen in IDLE at cycle N; mem_req asserted at N+1.
  - Earliest addr_ok at N+1, earliest data_ok at N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Ignored events (no state change):
  - mem_data_ok in IDLE or ADDR.
  - mem_addr_ok outside ADDR.
- Requests arriving outside IDLE are not sampled. A requester holding req simply waits.
- Simultaneous inst_req and data_req in IDLE are resolved by the grant rule. A tie never grants both.
- Writes: mem_data_ok is the write completion and is returned to the owner identically to a read.
- Reset mid-transaction: the in-flight response is dropped and no *_data_ok is produced. A late mem_data_ok after reset falls in IDLE and is ignored.

Decomposition:
- Shared package/header:
  - state encodings IDLE/ADDR/RESP.
  - owner encodings OWN_INST/OWN_DATA.
  - size encodings SIZE_B/SIZE_H/SIZE_W.
- One natural sub-module, arb_grant: a combinational grant decision plus the streak counter register.
- FSM, latch and response routing stay in the top module.

Test Plan:
- Reset then idle, inst_req=0 and data_req=0 for 10 cycles -> all outputs 0, state stays IDLE.
- inst_req only, addr=0xBFC00000, word read; slave addr_ok 1 cycle later, data_ok next, rdata=0x3C1D0001 -> mem_addr=0xBFC00000, inst_addr_ok 1 cycle, inst_data_ok with rdata 0x3C1D0001, data_* outputs stay 0.
- inst_req and data_req asserted together (data write, addr 0x00001000, wdata 0xDEADBEEF, size=2) -> data granted first with mem_wr=1; inst granted in the IDLE following data_data_ok.
- Both held continuously, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I...
- Slave stalls mem_addr_ok low for 7 cycles -> mem_req and latched fields stable throughout; no addr_ok to either requester until the slave accepts.
- rst pulsed in RESP with mem_data_ok arriving next cycle -> no *_data_ok pulse; FSM IDLE; streak=0.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like inst/data arbiter.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int unsigned STREAK_W = 4;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/arb_grant.sv
// Data-first grant decision with a bounded data streak so inst fetch cannot starve.
module arb_grant
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_idle,
    input  logic   i_inst_req,
    input  logic   i_data_req,
    output logic   o_grant,
    output owner_t o_owner
);

    logic [STREAK_W-1:0] r_streak;
    logic                w_data_wins;

    always_comb begin
        w_data_wins = i_data_req &&
                      (!i_inst_req || (r_streak < STREAK_W'(MAX_DATA_STREAK)));
        o_grant     = i_idle && (i_inst_req || i_data_req);
        o_owner     = w_data_wins ? OWN_DATA : OWN_INST;
    end

    // Streak only moves on a grant; it counts data wins that bypassed a waiting inst request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (o_grant) begin
            if (w_data_wins && i_inst_req) begin
                if (r_streak != '1) r_streak <= r_streak + 1'b1;
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like master port between inst and data requesters, one transaction in flight.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    state_t r_state;
    state_t w_state_nxt;
    owner_t r_owner;
    req_t   r_latch;
    logic   w_grant;
    owner_t w_gnt_owner;

    arb_grant #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_grant (
        .clk        (clk),
        .rst        (rst),
        .i_idle     (r_state == IDLE),
        .i_inst_req (inst_req),
        .i_data_req (data_req),
        .o_grant    (w_grant),
        .o_owner    (w_gnt_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_INST;
            r_latch <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_gnt_owner;
                if (w_gnt_owner == OWN_DATA)
                    r_latch <= '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
                else
                    r_latch <= '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = ADDR;
            end
            ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = r_latch.wr;
                mem_size  = r_latch.size;
                mem_addr  = r_latch.addr;
                mem_wdata = r_latch.wdata;
                if (mem_addr_ok) begin
                    w_state_nxt = RESP;
                    if (r_owner == OWN_DATA) data_addr_ok = 1'b1;
                    else                     inst_addr_ok = 1'b1;
                end
            end
            RESP: begin
                if (mem_data_ok) begin
                    w_state_nxt = IDLE;
                    if (r_owner == OWN_DATA) begin
                        data_data_ok = 1'b1;
                        data_rdata   = mem_rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_rdata;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: expected grants/responses queued at stimulus, popped at DUT output.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    sram_like_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        owner_t      owner;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        ok;
        int          lat;
        logic [3:0]  hs;      // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
        logic        req_in_resp;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } obs_t;

    exp_t exp_q[$];

    // Slave side of one transaction; only records what the DUT shows, checks happen in callers.
    task automatic serve(input logic [31:0] rd, input logic hold, output obs_t o);
        o.ok = 1'b0; o.lat = -1; o.hs = '0; o.req_in_resp = 1'b0; o.wr = 1'b0;
        o.size = '0; o.addr = '0; o.wdata = '0; o.irdata = '0; o.drdata = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
            #1;
            if (mem_req) begin
                o.ok = 1'b1; o.lat = c;
                break;
            end
        end
        if (!o.ok) return;
        mem_addr_ok = 1'b1;
        #1;
        o.hs[3] = inst_addr_ok; o.hs[2] = data_addr_ok;
        o.wr = mem_wr; o.size = mem_size; o.addr = mem_addr; o.wdata = mem_wdata;
        @(negedge clk);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = rd;
        if (!hold) begin
            if (o.hs[2]) data_req = 1'b0;
            else         inst_req = 1'b0;
        end
        #1;
        o.req_in_resp = mem_req;
        o.hs[1] = inst_data_ok; o.hs[0] = data_data_ok;
        o.irdata = inst_rdata; o.drdata = data_rdata;
        @(negedge clk);
        mem_data_ok = 1'b0; mem_rdata = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_addr_ok = (i % 3 == 1);
            mem_data_ok = (i % 2 == 0);
            mem_rdata   = 32'hFFFF_0000 | 32'(i);
            #1;
            n_checks++;
            if ({inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
                 mem_req, mem_wr, mem_size, mem_addr, mem_wdata} !== '0) begin
                n_errors++;
                $display("FAIL idle_outputs cycle %0d: mem_req=%b iaok=%b idok=%b daok=%b ddok=%b irdata=%h drdata=%h mem_addr=%h, required all zero",
                         i, mem_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                         inst_rdata, data_rdata, mem_addr);
            end
            n_checks++;
            if (dut.r_state !== IDLE) begin
                n_errors++;
                $display("FAIL idle_state cycle %0d: got %0d required %0d", i, dut.r_state, IDLE);
            end
        end
        @(negedge clk);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        #1;
    endtask

    task automatic test_inst_read();
        obs_t o;
        exp_t e;
        @(negedge clk);
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_W;
        inst_addr = 32'hBFC0_0000; inst_wdata = '0;
        exp_q.push_back('{OWN_INST, 1'b0, SIZE_W, 32'hBFC0_0000, 32'h0, 32'h3C1D_0001});
        serve(32'h3C1D_0001, 1'b0, o);
        e = exp_q.pop_front();
        n_checks++;
        if (o.ok !== 1'b1 || o.lat != 0) begin
            n_errors++;
            $display("FAIL inst_latency: ok=%b lat=%0d required ok=1 lat=0", o.ok, o.lat);
        end
        n_checks++;
        if ({o.wr, o.size, o.addr} !== {e.wr, e.size, e.addr}) begin
            n_errors++;
            $display("FAIL inst_mem_fields: got wr=%b size=%0d addr=%h required wr=%b size=%0d addr=%h",
                     o.wr, o.size, o.addr, e.wr, e.size, e.addr);
        end
        n_checks++;
        if (o.hs !== 4'b1010) begin
            n_errors++;
            $display("FAIL inst_handshakes: got %b required 1010", o.hs);
        end
        n_checks++;
        if ({o.irdata, o.drdata} !== {e.rdata, 32'h0}) begin
            n_errors++;
            $display("FAIL inst_rdata: got inst=%h data=%h required inst=%h data=0", o.irdata, o.drdata, e.rdata);
        end
        n_checks++;
        if (o.req_in_resp !== 1'b0) begin
            n_errors++;
            $display("FAIL inst_mem_req_in_resp: got %b required 0", o.req_in_resp);
        end
    endtask

    task automatic test_tie_write();
        obs_t o;
        exp_t e;
        @(negedge clk);
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_W;
        inst_addr = 32'hBFC0_0004; inst_wdata = '0;
        data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_W;
        data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
        exp_q.push_back('{OWN_DATA, 1'b1, SIZE_W, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0});
        exp_q.push_back('{OWN_INST, 1'b0, SIZE_W, 32'hBFC0_0004, 32'h0, 32'h2408_0005});
        for (int t = 0; t < 2; t++) begin
            serve((t == 0) ? 32'h0 : 32'h2408_0005, 1'b0, o);
            e = exp_q.pop_front();
            n_checks++;
            if (o.ok !== 1'b1 || o.lat != 0) begin
                n_errors++;
                $display("FAIL tie_latency[%0d]: ok=%b lat=%0d required ok=1 lat=0", t, o.ok, o.lat);
            end
            n_checks++;
            if ({o.wr, o.size, o.addr, o.wdata} !== {e.wr, e.size, e.addr, e.wdata}) begin
                n_errors++;
                $display("FAIL tie_mem_fields[%0d]: got wr=%b size=%0d addr=%h wdata=%h required wr=%b size=%0d addr=%h wdata=%h",
                         t, o.wr, o.size, o.addr, o.wdata, e.wr, e.size, e.addr, e.wdata);
            end
            n_checks++;
            if (o.hs !== ((e.owner == OWN_DATA) ? 4'b0101 : 4'b1010)) begin
                n_errors++;
                $display("FAIL tie_handshakes[%0d]: got %b required owner %s", t, o.hs,
                         (e.owner == OWN_DATA) ? "data 0101" : "inst 1010");
            end
            n_checks++;
            if ({o.irdata, o.drdata} !== ((e.owner == OWN_DATA) ? {32'h0, e.rdata} : {e.rdata, 32'h0})) begin
                n_errors++;
                $display("FAIL tie_rdata[%0d]: got inst=%h data=%h expected owner rdata %h", t, o.irdata, o.drdata, e.rdata);
            end
        end
    endtask

    task automatic test_streak();
        obs_t o;
        exp_t e;
        @(negedge clk);
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_W; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h0000_2000; data_wdata = '0;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                exp_q.push_back('{OWN_INST, 1'b0, SIZE_W, 32'hBFC0_0100, 32'h0, 32'hA000_0000 + 32'(i)});
            else
                exp_q.push_back('{OWN_DATA, 1'b0, SIZE_W, 32'h0000_2000, 32'h0, 32'hA000_0000 + 32'(i)});
        end
        for (int i = 0; i < 10; i++) begin
            serve(32'hA000_0000 + 32'(i), 1'b1, o);
            e = exp_q.pop_front();
            n_checks++;
            if (o.ok !== 1'b1 || o.addr !== e.addr || o.hs !== ((e.owner == OWN_DATA) ? 4'b0101 : 4'b1010)) begin
                n_errors++;
                $display("FAIL streak_grant[%0d]: got ok=%b addr=%h hs=%b required grant %s addr=%h",
                         i, o.ok, o.addr, o.hs, (e.owner == OWN_DATA) ? "D" : "I", e.addr);
            end
            n_checks++;
            if ({o.irdata, o.drdata} !== ((e.owner == OWN_DATA) ? {32'h0, e.rdata} : {e.rdata, 32'h0})) begin
                n_errors++;
                $display("FAIL streak_rdata[%0d]: got inst=%h data=%h expected owner rdata %h", i, o.irdata, o.drdata, e.rdata);
            end
        end
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_stall();
        exp_t e;
        logic seen;
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_H;
        data_addr = 32'h2000_0002; data_wdata = 32'h1234_5678;
        exp_q.push_back('{OWN_DATA, 1'b0, SIZE_H, 32'h2000_0002, 32'h1234_5678, 32'h0000_BEEF});
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = mem_req;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL stall_req_timeout: mem_req=0 after 20 cycles, required 1");
        end
        data_addr = 32'hFFFF_FFFF; data_size = SIZE_B; data_wdata = '0; data_wr = 1'b1;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata} !== {1'b1, e.wr, e.size, e.addr, e.wdata}) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got req=%b wr=%b size=%0d addr=%h wdata=%h required req=1 wr=%b size=%0d addr=%h wdata=%h",
                         s, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, e.wr, e.size, e.addr, e.wdata);
            end
            n_checks++;
            if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin
                n_errors++;
                $display("FAIL stall_no_addr_ok[%0d]: got inst=%b data=%b required 0 0", s, inst_addr_ok, data_addr_ok);
            end
        end
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1;
        n_checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
            n_errors++;
            $display("FAIL stall_accept: got inst=%b data=%b required 0 1", inst_addr_ok, data_addr_ok);
        end
        @(negedge clk);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = e.rdata; data_req = 1'b0;
        #1;
        n_checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== {1'b0, 1'b1, 32'h0, e.rdata}) begin
            n_errors++;
            $display("FAIL stall_resp: got idok=%b ddok=%b irdata=%h drdata=%h required 0 1 0 %h",
                     inst_data_ok, data_data_ok, inst_rdata, data_rdata, e.rdata);
        end
        @(negedge clk);
        mem_data_ok = 1'b0; mem_rdata = '0; data_wr = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_W; inst_addr = 32'hBFC0_0008;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h0000_3000;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            seen = mem_req;
        end
        mem_addr_ok = 1'b1;
        #1;
        n_checks++;
        if (!seen || data_addr_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_grant: seen=%b data_addr_ok=%b required 1 1", seen, data_addr_ok);
        end
        @(negedge clk);
        mem_addr_ok = 1'b0; rst = 1'b1; inst_req = 1'b0; data_req = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA;
        #1;
        n_checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !== '0) begin
            n_errors++;
            $display("FAIL rstmid_no_data_ok: got idok=%b ddok=%b irdata=%h drdata=%h required all 0",
                     inst_data_ok, data_data_ok, inst_rdata, data_rdata);
        end
        n_checks++;
        if (dut.r_state !== IDLE || mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_state: got state=%0d mem_req=%b required state=%0d mem_req=0", dut.r_state, mem_req, IDLE);
        end
        n_checks++;
        if (dut.u_grant.r_streak !== 4'd0) begin
            n_errors++;
            $display("FAIL rstmid_streak: got %0d required 0", dut.u_grant.r_streak);
        end
        @(negedge clk);
        mem_data_ok = 1'b0; mem_rdata = '0;
        #1;
        n_checks++;
        if (dut.r_state !== IDLE) begin
            n_errors++;
            $display("FAIL rstmid_after: got state=%0d required %0d", dut.r_state, IDLE);
        end
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = '0; inst_addr = '0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        test_reset();
        test_inst_read();
        test_tie_write();
        test_streak();
        test_stall();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
